// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding,
// supported oversampling ratios and the per-frame configuration snapshot.
package uart_rx_pkg;

    localparam int unsigned PRESC_W   = 5;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [PRESC_W-1:0] PRESC_8  = PRESC_W'(8);
    localparam logic [PRESC_W-1:0] PRESC_16 = PRESC_W'(16);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               par_en;
        logic               par_typ;
    } rx_cfg_t;

    // Any ratio other than 16 falls back to 8.
    function automatic logic [PRESC_W-1:0] legal_presc(input logic [PRESC_W-1:0] p);
        return (p == PRESC_16) ? PRESC_16 : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample-tick and bit-index counters; run while enabled, held at zero otherwise.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en_i,
    input  logic [PRESC_W-1:0]   presc_i,
    output logic [PRESC_W-1:0]   edge_cnt_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o
);

    logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 wrap_c;

    assign wrap_c = (edge_cnt_q == presc_i - PRESC_W'(1));

    always_comb begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (en_i) begin
            if (wrap_c) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_W'(1);
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop bits from the
// sampler's voted bit, reports the byte and parity/stop errors.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESC_W-1:0]    edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_e             state_q, state_d;
    rx_cfg_t               cfg_q, cfg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  samp_en_q, samp_en_d;

    logic                  cnt_en_c;
    logic                  bit_end_c;
    logic [DATA_WIDTH-1:0] wr_mask_c;

    assign cnt_en_c = (state_q != IDLE);

    uart_rx_edge_bit_counter u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (cnt_en_c),
        .presc_i    (cfg_q.presc),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt)
    );

    assign bit_end_c = (edge_cnt == cfg_q.presc - PRESC_W'(1));

    // Data bit k lands in P_DATA[k] while bit_cnt == k+1 (LSB first).
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_wr_mask
        assign wr_mask_c[g] = (bit_cnt == BIT_CNT_W'(g + 1));
    end

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    cfg_d     = '{presc: legal_presc(Prescale), par_en: PAR_EN, par_typ: PAR_TYP};
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    p_data_d = (p_data_q & ~wr_mask_c) | ({DATA_WIDTH{sampled_bit}} & wr_mask_c);
                    if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) begin
                        state_d = cfg_q.par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    par_err_d = (sampled_bit != ((^p_data_q) ^ cfg_q.par_typ));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    stp_err_d = ~sampled_bit;
                    dv_d      = sampled_bit & ~par_err_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        samp_en_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            samp_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            samp_en_q <= samp_en_d;
        end
    end

    assign dat_samp_en = samp_en_q;
    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule
